// File: rtl/nn_act_pkg.sv
// nn_act_pkg: shared widths, encodings and data type for the PWL activation unit
package nn_act_pkg;
    localparam int ACT_ADDR_W = 4;
    localparam int ACT_FRAC_W = 4;
    localparam int ACT_INIT_RELU = 0;
    localparam int ACT_INIT_ZERO = 1;
    localparam logic ACT_MODE_STEP = 1'b0;
    localparam logic ACT_MODE_INTERP = 1'b1;
    typedef logic signed [ACT_ADDR_W+ACT_FRAC_W-1:0] act_data_t;
endpackage

// File: rtl/pwl_lut_bank.sv
// pwl_lut_bank: writable activation table with reset preload and base/next read
// Ports: clk, rst (sync, active-low), we/waddr/wdata write port,
//        raddr lookup index, base = lut[raddr], next = neighbouring entry
module pwl_lut_bank
    import nn_act_pkg::*;
#(
    parameter int ADDR_W = ACT_ADDR_W,
    parameter int FRAC_W = ACT_FRAC_W,
    parameter int DATA_W = ADDR_W + FRAC_W,
    parameter int INIT_MODE = ACT_INIT_RELU
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic signed [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0]        raddr,
    output logic signed [DATA_W-1:0] base,
    output logic signed [DATA_W-1:0] next
);
    localparam logic [ADDR_W-1:0] MAX_POS = {1'b0, {(ADDR_W-1){1'b1}}};
    logic signed [DATA_W-1:0] lut [2**ADDR_W];
    logic [ADDR_W-1:0] naddr;
    // the -1 segment wraps to entry 0 for continuity across zero; the top positive segment saturates
    always_comb naddr = &raddr ? '0 : raddr == MAX_POS ? raddr : raddr + ADDR_W'(1);
    assign base = lut[raddr];
    assign next = lut[naddr];
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2**ADDR_W; i++)
                lut[i] <= (INIT_MODE == ACT_INIT_RELU && i < 2**(ADDR_W-1)) ? DATA_W'(i << FRAC_W) : '0;
        end else if (we) begin
            lut[waddr] <= wdata;
        end
    end
endmodule

// File: rtl/pwl_activation_unit.sv
// pwl_activation_unit: 3-stage piecewise-linear activation with valid/ready backpressure
// Ports: clk, rst (sync, active-low), in_valid/in_ready/in_x/mode input handshake,
//        out_valid/out_ready/out_y result handshake, cfg_we/cfg_addr/cfg_data table write
module pwl_activation_unit
    import nn_act_pkg::*;
#(
    parameter int ADDR_W = ACT_ADDR_W,
    parameter int FRAC_W = ACT_FRAC_W,
    parameter int DATA_W = ADDR_W + FRAC_W,
    parameter int INIT_MODE = ACT_INIT_RELU
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_x,
    input  logic                     mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_y,
    input  logic                     cfg_we,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic signed [DATA_W-1:0] cfg_data
);
    localparam int PW = DATA_W + FRAC_W + 2;
    logic adv;
    logic signed [DATA_W-1:0] lut_base, lut_next;
    logic v1, v2, mode1;
    logic signed [DATA_W-1:0] base1, next1, base2;
    logic [FRAC_W-1:0] frac1;
    logic signed [DATA_W:0] diff;
    logic signed [PW-1:0] prod, prod2;
    assign adv = !out_valid || out_ready;
    assign in_ready = adv;
    pwl_lut_bank #(
        .ADDR_W(ADDR_W), .FRAC_W(FRAC_W), .DATA_W(DATA_W), .INIT_MODE(INIT_MODE)
    ) u_lut (
        .clk(clk), .rst(rst), .we(cfg_we), .waddr(cfg_addr), .wdata(cfg_data),
        .raddr(in_x[DATA_W-1 -: ADDR_W]), .base(lut_base), .next(lut_next)
    );
    assign diff = $signed({next1[DATA_W-1], next1}) - $signed({base1[DATA_W-1], base1});
    // fraction is unsigned, so it gets a zero sign bit before the signed multiply
    assign prod = mode1 == ACT_MODE_INTERP ? PW'(diff) * PW'($signed({1'b0, frac1})) : '0;
    always_ff @(posedge clk) begin
        if (!rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            out_valid <= 1'b0;
            out_y <= '0;
        end else if (adv) begin
            v1 <= in_valid;
            base1 <= lut_base;
            next1 <= lut_next;
            frac1 <= in_x[FRAC_W-1:0];
            mode1 <= mode;
            v2 <= v1;
            base2 <= base1;
            prod2 <= prod;
            out_valid <= v2;
            // result lies between base and next, so plain truncation cannot overflow
            out_y <= DATA_W'(PW'(base2) + (prod2 >>> FRAC_W));
        end
    end
endmodule

// File: tb/tb_pwl_activation_unit.sv
// tb_pwl_activation_unit: directed self-checking bench for pwl_activation_unit
module tb_pwl_activation_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0, in_ready, mode = 1'b1;
    logic [7:0] in_x = '0, out_y, cfg_data = '0;
    logic out_valid, out_ready = 1'b1, cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    pwl_activation_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic single(input logic [7:0] x, input logic m, input logic [7:0] exp, input string tag);
        @(negedge clk);
        in_x = x; mode = m; in_valid = 1'b1;
        #1 check({tag, "_rdy"}, {7'd0, in_ready}, 8'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_lat1"}, {7'd0, out_valid}, 8'd0);
        @(negedge clk);
        check({tag, "_lat2"}, {7'd0, out_valid}, 8'd0);
        @(negedge clk);
        check({tag, "_vld"}, {7'd0, out_valid}, 8'd1);
        check(tag, out_y, exp);
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] xs [8] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        logic [7:0] ys [8] = '{8'd0, 8'd17, 8'd34, 8'd51, 8'd68, 8'd85, 8'd102, 8'd112};
        int sent, rcv;
        logic stalled;
        logic [7:0] held;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("rst_vld", {7'd0, out_valid}, 8'd0);
        check("rst_y", out_y, 8'd0);
        check("rst_rdy", {7'd0, in_ready}, 8'd1);

        single(8'h25, 1'b1, 8'd37, "relu_25");
        single(8'h7F, 1'b1, 8'd112, "relu_sat");
        single(8'hF8, 1'b1, 8'd0, "relu_wrap");
        single(8'h80, 1'b1, 8'd0, "relu_neg");
        single(8'h25, 1'b0, 8'd32, "step_25");
        single(8'h2F, 1'b1, 8'd47, "interp_2f");

        sent = 0; rcv = 0; stalled = 1'b0; held = '0;
        for (int c = 0; c < 40 && rcv < 8; c++) begin
            @(negedge clk);
            in_valid = sent < 8;
            in_x = xs[sent < 8 ? sent : 0];
            mode = 1'b1;
            out_ready = !(c >= 5 && c < 8);
            #1;
            if (stalled) begin
                check("hold_vld", {7'd0, out_valid}, 8'd1);
                check("hold_y", out_y, held);
            end
            if (out_valid && !out_ready) check("stall_rdy", {7'd0, in_ready}, 8'd0);
            if (out_valid && out_ready) begin
                check($sformatf("stream_%0d", rcv), out_y, ys[rcv < 8 ? rcv : 0]);
                rcv++;
            end
            stalled = out_valid && !out_ready;
            held = out_y;
            if (in_valid && in_ready) sent++;
        end
        check("stream_sent", 8'(sent), 8'd8);
        check("stream_rcv", 8'(rcv), 8'd8);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("stream_nodup", {7'd0, out_valid}, 8'd0);

        cfg_write(4'd3, 8'd127);
        cfg_write(4'd4, 8'h80);
        single(8'h38, 1'b1, 8'hFF, "neg_slope");
        single(8'h30, 1'b1, 8'd127, "written_3");

        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = 8'd50;
        in_valid = 1'b1; in_x = 8'h20; mode = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("same_cyc_vld", {7'd0, out_valid}, 8'd1);
        check("same_cyc_old", out_y, 8'd32);
        single(8'h20, 1'b1, 8'd50, "after_write");

        @(negedge clk);
        in_valid = 1'b1; in_x = 8'h11;
        @(negedge clk);
        in_x = 8'h22;
        @(negedge clk);
        in_x = 8'h33;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b0;
        cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = 8'd99;
        @(negedge clk);
        rst = 1'b1; cfg_we = 1'b0;
        check("mid_rst_vld", {7'd0, out_valid}, 8'd0);
        check("mid_rst_y", out_y, 8'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("flush_%0d", i), {7'd0, out_valid}, 8'd0);
        end
        single(8'h20, 1'b1, 8'd32, "reloaded");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
